tcm_ctrl: RTL and testbench
===========================

TCM_CTRL -- requirements
Module: tcm_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 512, number of 32-bit words in the tightly coupled memory.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 0, extra data-port latency cycles, legal range 0..7.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port ireq  input  1  instruction fetch request.
REQ-006 SHALL provide port iaddr  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL provide port idata  output  32  fetched instruction word.
REQ-008 SHALL provide port ivalid  output  1  idata valid.
REQ-009 SHALL provide port dreq  input  1  data access request; read when dwe==0, write otherwise.
REQ-010 SHALL provide port daddr  input  32  data byte address; bits [1:0] ignored.
REQ-011 SHALL provide port dwdata  input  32  write data.
REQ-012 SHALL provide port dwe  input  4  per-byte write enable; bit n enables byte lane n (bits 8n+7:8n).
REQ-013 SHALL provide port drdata  output  32  read data.
REQ-014 SHALL provide port drvalid  output  1  one-cycle completion pulse for reads and writes.
REQ-015 SHALL provide port derr  output  1  out-of-range flag, qualified by drvalid.

Function
REQ-016 Word index SHALL be addr[31:2]; an index >= DEPTH SHALL be out of range.
REQ-017 Instruction port: ireq sampled high at edge N SHALL give ivalid=1 and idata=mem[iaddr index] after edge N; ivalid SHALL be 0 after any edge where ireq=0.
REQ-018 Instruction port SHALL be fully pipelined: back-to-back ireq yields back-to-back ivalid, no stalls.
REQ-019 An out-of-range fetch SHALL return idata=0 with ivalid=1.
REQ-020 Data FSM states SHALL be IDLE, WAIT, RESP.
REQ-021 IDLE with dreq=1 SHALL latch daddr, dwdata and dwe, then go to RESP if WAIT_CYCLES==0, else to WAIT with counter loaded to WAIT_CYCLES-1.
REQ-022 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where counter==0.
REQ-023 On the edge entering RESP, the controller SHALL commit the write (enabled bytes only, others unchanged) or capture read data into drdata.
REQ-024 In RESP, drvalid SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-025 Total data latency SHALL be 1+WAIT_CYCLES edges from request acceptance to drvalid.
REQ-026 dreq in WAIT or RESP SHALL be ignored; the requester holds dreq until drvalid and may re-request in the cycle after drvalid.
REQ-027 drdata SHALL hold its last read value after writes and until the next read completes.
REQ-028 An out-of-range access SHALL drop the write, return drdata=0 for reads, and assert derr=1 with drvalid; otherwise derr=0.
REQ-029 Simultaneous fetch and data write to the same word on the same edge SHALL return the pre-write word on idata (read-before-write).
REQ-030 A fetch on the edge after a write commit SHALL return the new data.

Reset
REQ-031 rst=1 SHALL immediately force FSM=IDLE, counter=0, ivalid=0, idata=0, drvalid=0, drdata=0, derr=0.
REQ-032 Memory contents SHALL NOT be reset; an optional init file SHALL be loadable at elaboration only.
REQ-033 Reset during WAIT SHALL abandon the pending access; the write SHALL NOT be committed.
REQ-034 After reset deasserts, the first dreq/ireq SHALL be accepted on the first rising clk edge.

Verification
REQ-035 WAIT_CYCLES=0: write 0xDEADBEEF with dwe=4'hF to 0x10, then read 0x10 -> drvalid 1 edge after each request, drdata=0xDEADBEEF, derr=0.
REQ-036 Byte lanes: word 0x20=0x11223344, write 0xAABBCCDD with dwe=4'b0101 -> read returns 0x11BB33DD.
REQ-037 WAIT_CYCLES=3: read request -> drvalid exactly 4 edges after acceptance; dreq toggling during WAIT causes no extra drvalid.
REQ-038 Same edge: fetch 0x40 and write 0x12345678 to 0x40 (old 0x0) -> idata=0x0; fetch on next edge -> idata=0x12345678.
REQ-039 DEPTH=512: write to 0x800 -> derr=1 with drvalid, memory unchanged; read 0x800 -> drdata=0, derr=1.
REQ-040 WAIT_CYCLES=3: assert rst in the second WAIT cycle of a write to 0x8 -> outputs 0 immediately, no drvalid, read of 0x8 after reset returns the old value.

Source files
------------

// File: rtl/tcm_ctrl.sv
// rtl/tcm_ctrl.sv - tightly coupled memory controller with pipelined fetch port and wait-stated data port
module tcm_ctrl #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        ivalid,
    input  logic        dreq,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        drvalid,
    output logic        derr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // WAIT is entered with the counter already one below the wait count,
    // so the edge seeing zero is the last wait edge.
    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic [31:0] drdata_q;
    logic        drvalid_q;
    logic        derr_q;
    logic [31:0] idata_q;
    logic        ivalid_q;

    logic [31:0] mem [DEPTH];

    logic [29:0] acc_idx;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_we;
    logic        acc_in_range;
    logic [31:0] acc_word;
    logic        commit;
    logic [29:0] f_idx;
    logic        f_in_range;
    logic        unused_ok;

    // Byte-offset bits of both addresses carry no meaning for word accesses
    assign unused_ok = ^{iaddr[1:0], daddr[1:0]};

    // Select the access being committed: live inputs when a zero-wait request
    // is accepted straight from IDLE, otherwise the latched request.
    always_comb begin
        acc_idx      = idx_q;
        acc_wdata    = wdata_q;
        acc_we       = we_q;
        if (state_q == S_IDLE) begin
            acc_idx   = daddr[31:2];
            acc_wdata = dwdata;
            acc_we    = dwe;
        end
        acc_in_range = (acc_idx < 30'(DEPTH));
        acc_word     = acc_in_range ? mem[acc_idx[AW-1:0]] : 32'h0;
        commit       = ((state_q == S_IDLE) && dreq && (WAIT_CYCLES == 0)) ||
                       ((state_q == S_WAIT) && (cnt_q == 3'd0));
        f_idx        = iaddr[31:2];
        f_in_range   = (f_idx < 30'(DEPTH));
    end

    // Array write on the edge entering RESP; only enabled lanes change and the
    // array itself is never cleared. Requesters keep dreq low during rst.
    always_ff @(posedge clk) begin
        if (commit && acc_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_we[b]) begin
                    mem[acc_idx[AW-1:0]][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Instruction port: one-cycle registered read, sees the array before any
    // write committed on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ivalid_q <= 1'b0;
            idata_q  <= 32'h0;
        end else begin
            ivalid_q <= ireq;
            if (ireq) begin
                idata_q <= f_in_range ? mem[f_idx[AW-1:0]] : 32'h0;
            end
        end
    end

    // Data-port FSM with registered completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            idx_q     <= 30'h0;
            wdata_q   <= 32'h0;
            we_q      <= 4'h0;
            drdata_q  <= 32'h0;
            drvalid_q <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            drvalid_q <= 1'b0;
            derr_q    <= 1'b0;
            if (commit) begin
                drvalid_q <= 1'b1;
                derr_q    <= !acc_in_range;
                if (acc_we == 4'h0) begin
                    drdata_q <= acc_word;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (dreq) begin
                        idx_q   <= daddr[31:2];
                        wdata_q <= dwdata;
                        we_q    <= dwe;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign idata   = idata_q;
    assign ivalid  = ivalid_q;
    assign drdata  = drdata_q;
    assign drvalid = drvalid_q;
    assign derr    = derr_q;

endmodule

// File: tb/tb_tcm_ctrl.sv
// tb/tb_tcm_ctrl.sv - randomized self-checking bench for tcm_ctrl at zero and three wait cycles
module tb_tcm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq    [2];
    logic [31:0] iaddr   [2];
    logic [31:0] idata   [2];
    logic        ivalid  [2];
    logic        dreq    [2];
    logic [31:0] daddr   [2];
    logic [31:0] dwdata  [2];
    logic [3:0]  dwe     [2];
    logic [31:0] drdata  [2];
    logic        drvalid [2];
    logic        derr    [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word array per instance, which words hold defined data,
    // and the last completed read value.
    logic [31:0] mdl_mem   [2][512];
    bit          mdl_known [2][512];
    logic [31:0] mdl_rd    [2];
    bit          mdl_rd_ok [2];

    always #5 clk = ~clk;

    tcm_ctrl #(.DEPTH(512), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .ireq(ireq[0]), .iaddr(iaddr[0]), .idata(idata[0]), .ivalid(ivalid[0]),
        .dreq(dreq[0]), .daddr(daddr[0]), .dwdata(dwdata[0]), .dwe(dwe[0]),
        .drdata(drdata[0]), .drvalid(drvalid[0]), .derr(derr[0])
    );

    tcm_ctrl #(.DEPTH(512), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ireq(ireq[1]), .iaddr(iaddr[1]), .idata(idata[1]), .ivalid(ivalid[1]),
        .dreq(dreq[1]), .daddr(daddr[1]), .dwdata(dwdata[1]), .dwe(dwe[1]),
        .drdata(drdata[1]), .drvalid(drvalid[1]), .derr(derr[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int latency_of(input int s);
        return 1 + ((s == 0) ? 0 : 3);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        a = $urandom();
        case (r)
            0:       a = a | 32'h8000_0000;
            1:       a = 32'h800 | {30'h0, a[1:0]};
            2:       a = {30'd511, a[1:0]};
            default: a = {26'h0, a[5:0]};
        endcase
        return a;
    endfunction

    task automatic check_reset_outputs(input int s, input string tag);
        check({tag, "_ivalid"}, {31'h0, ivalid[s]}, 32'h0);
        check({tag, "_idata"}, idata[s], 32'h0);
        check({tag, "_drvalid"}, {31'h0, drvalid[s]}, 32'h0);
        check({tag, "_drdata"}, drdata[s], 32'h0);
        check({tag, "_derr"}, {31'h0, derr[s]}, 32'h0);
    endtask

    // Full data transaction holding dreq until completion, checked against the model
    task automatic data_access(input int s, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] we);
        int n;
        bit seen;
        bit oor;
        logic [29:0] idx;
        idx  = addr[31:2];
        oor  = (idx >= 30'd512);
        @(negedge clk);
        dreq[s] = 1'b1; daddr[s] = addr; dwdata[s] = wd; dwe[s] = we;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (drvalid[s]) seen = 1;
        end
        check("latency", n, latency_of(s));
        if (!oor && we != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (we[b]) mdl_mem[s][idx[8:0]][8*b +: 8] = wd[8*b +: 8];
            if (we == 4'hF) mdl_known[s][idx[8:0]] = 1'b1;
        end
        if (we == 4'h0) begin
            mdl_rd[s]    = oor ? 32'h0 : mdl_mem[s][idx[8:0]];
            mdl_rd_ok[s] = oor || mdl_known[s][idx[8:0]];
        end
        check("derr", {31'h0, derr[s]}, {31'h0, oor});
        if (mdl_rd_ok[s]) check("drdata", drdata[s], mdl_rd[s]);
        @(negedge clk);
        dreq[s] = 1'b0; dwe[s] = 4'h0;
        @(posedge clk); #1;
        check("drvalid_pulse", {31'h0, drvalid[s]}, 32'h0);
    endtask

    // Random back-to-back fetch burst; no data writes are in flight meanwhile
    task automatic fetch_burst(input int s, input int cycles);
        bit req;
        logic [31:0] a;
        logic [29:0] idx;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) != 0);
            a   = rand_addr();
            ireq[s] = req; iaddr[s] = a;
            @(posedge clk); #1;
            check("ivalid", {31'h0, ivalid[s]}, {31'h0, req});
            idx = a[31:2];
            if (req) begin
                if (idx >= 30'd512) check("idata_oor", idata[s], 32'h0);
                else if (mdl_known[s][idx[8:0]]) check("idata", idata[s], mdl_mem[s][idx[8:0]]);
            end
        end
        @(negedge clk);
        ireq[s] = 1'b0;
    endtask

    initial begin
        int n;
        int extra;
        bit seen;
        logic [31:0] oldv;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            ireq[s] = 0; iaddr[s] = 0; dreq[s] = 0; daddr[s] = 0; dwdata[s] = 0; dwe[s] = 0;
            mdl_rd[s] = 0; mdl_rd_ok[s] = 1;
            for (int i = 0; i < 512; i++) begin
                mdl_mem[s][i] = 0; mdl_known[s][i] = 0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0, "rst0");
        check_reset_outputs(1, "rst3");
        @(negedge clk);
        rst = 1'b0;

        // Full-word write then read back, zero wait
        data_access(0, 32'h10, 32'hDEADBEEF, 4'hF);
        data_access(0, 32'h10, 32'h0, 4'h0);
        check("wr_rd_deadbeef", drdata[0], 32'hDEADBEEF);

        // Partial byte-lane write
        data_access(0, 32'h20, 32'h11223344, 4'hF);
        data_access(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        data_access(0, 32'h20, 32'h0, 4'h0);
        check("byte_lanes", drdata[0], 32'h11BB33DD);

        // Fetch and write of the same word on one edge
        data_access(0, 32'h40, 32'h0, 4'hF);
        @(negedge clk);
        dreq[0] = 1; daddr[0] = 32'h40; dwdata[0] = 32'h12345678; dwe[0] = 4'hF;
        ireq[0] = 1; iaddr[0] = 32'h40;
        @(posedge clk); #1;
        check("same_edge_idata", idata[0], 32'h0);
        check("same_edge_drvalid", {31'h0, drvalid[0]}, 32'h1);
        @(negedge clk);
        dreq[0] = 0; dwe[0] = 0;
        @(posedge clk); #1;
        check("next_edge_idata", idata[0], 32'h12345678);
        @(negedge clk);
        ireq[0] = 0;
        mdl_mem[0][16] = 32'h12345678; mdl_known[0][16] = 1;

        // Out-of-range write and read; word 0 must not be aliased
        data_access(0, 32'h0, 32'h0BADC0DE, 4'hF);
        data_access(0, 32'h800, 32'hCAFEF00D, 4'hF);
        data_access(0, 32'h800, 32'h0, 4'h0);
        check("oor_read_zero", drdata[0], 32'h0);
        data_access(0, 32'h0, 32'h0, 4'h0);
        check("oor_no_alias", drdata[0], 32'h0BADC0DE);

        // Three-wait read with dreq toggling during WAIT
        data_access(1, 32'h10, 32'h5A5AA5A5, 4'hF);
        @(negedge clk);
        dreq[1] = 1; daddr[1] = 32'h10; dwe[1] = 4'h0;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (drvalid[1]) seen = 1;
            else begin
                @(negedge clk);
                dreq[1] = 1'($urandom_range(0, 1));
            end
        end
        check("wait3_latency", n, 4);
        check("wait3_drdata", drdata[1], 32'h5A5AA5A5);
        mdl_rd[1] = 32'h5A5AA5A5; mdl_rd_ok[1] = 1;
        @(negedge clk);
        dreq[1] = 0;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (drvalid[1]) extra++;
        end
        check("wait3_no_extra", extra, 0);

        // Reset during the second WAIT cycle of a write
        oldv = $urandom() | 32'h1;
        data_access(1, 32'h8, oldv, 4'hF);
        data_access(1, 32'h8, 32'h0, 4'h0);
        @(negedge clk);
        dreq[1] = 1; daddr[1] = 32'h8; dwdata[1] = ~oldv; dwe[1] = 4'hF;
        ireq[1] = 1; iaddr[1] = 32'h8;
        @(posedge clk); #1;
        check("pre_rst_idata", idata[1], oldv);
        @(negedge clk);
        ireq[1] = 0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(1, "async_rst");
        @(negedge clk);
        dreq[1] = 0; dwe[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_drvalid", {31'h0, drvalid[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mdl_rd[s] = 0; mdl_rd_ok[s] = 1;
        end
        data_access(1, 32'h8, 32'h0, 4'h0);
        check("rst_write_dropped", drdata[1], oldv);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) data_access(s, 32'(i * 4), $urandom(), 4'hF);
            data_access(s, 32'h7FC, $urandom(), 4'hF);
            repeat (60) begin
                if ($urandom_range(0, 2) == 0) fetch_burst(s, $urandom_range(1, 8));
                else if ($urandom_range(0, 1) == 0) data_access(s, rand_addr(), $urandom(), 4'h0);
                else data_access(s, rand_addr(), $urandom(), 4'($urandom_range(1, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
